frame_clear_mux: RTL and testbench

//  Final pixel stage between the draw controller and the VGA adapter write port.
//  Per frame: wait for frame_tick, wipe the screen with BG_COLOR, then let the draw controller's

---
 rtl/frame_pkg.sv | 25 ++
 rtl/frame_clear_mux_clear_scanner.sv | 40 ++++
 rtl/frame_clear_mux.sv | 137 +++++++++++++
 tb/tb_frame_clear_mux.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/frame_pkg.sv
// Shared types and widths for the frame clear/draw pixel stage.
// Border colouring is enabled by defining FRAME_BORDER_EN.
package frame_pkg;

  localparam int COORD_W = 10;
  localparam int COLOR_W = 3;

  typedef enum logic [1:0] {
    WAIT,
    CLEAR,
    DRAW
  } frame_state_t;

  function automatic logic on_border(
    input logic [COORD_W-1:0] x,
    input logic [COORD_W-1:0] y,
    input int                 w,
    input int                 h
  );
    return (x == '0) || (y == '0) ||
           (x == COORD_W'(w - 1)) ||
           (y == COORD_W'(h - 1));
  endfunction

endpackage

// File: rtl/frame_clear_mux_clear_scanner.sv
// Raster x/y counter used to sweep the whole screen during CLEAR.
// Optional feature macro FRAME_BORDER_EN does not affect this file.
module clear_scanner
  import frame_pkg::*;
#(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               advance,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               last
);

  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(SCREEN_W - 1);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(SCREEN_H - 1);

  assign last = (x == X_MAX) && (y == Y_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x <= '0;
      y <= '0;
    end else if (start) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      if (x == X_MAX) begin
        x <= '0;
        y <= (y == Y_MAX) ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_clear_mux.sv
// Per-frame screen wipe followed by gated pass-through of drawn pixels.
// Define FRAME_BORDER_EN to paint and protect a one-pixel screen border.
module frame_clear_mux
  import frame_pkg::*;
#(
  parameter int                  SCREEN_W     = 160,
  parameter int                  SCREEN_H     = 120,
  parameter logic [COLOR_W-1:0]  BG_COLOR     = 3'b000,
  parameter logic [COLOR_W-1:0]  BORDER_COLOR = 3'b111
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic [COORD_W-1:0] in_x,
  input  logic [COORD_W-1:0] in_y,
  input  logic [COLOR_W-1:0] in_color,
  input  logic               in_plot,
  input  logic               in_frame_done,
  output logic               draw_en,
  output logic [COORD_W-1:0] vga_x,
  output logic [COORD_W-1:0] vga_y,
  output logic [COLOR_W-1:0] vga_color,
  output logic               vga_plot,
  output logic               busy,
  output logic               overrun
);

`ifdef FRAME_BORDER_EN
  localparam logic BORDER_ON = 1'b1;
`else
  localparam logic BORDER_ON = 1'b0;
`endif

  localparam logic [COORD_W-1:0] X_LIM = COORD_W'(SCREEN_W);
  localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(SCREEN_H);

  frame_state_t state, next;

  logic               scan_start;
  logic               scan_adv;
  logic               scan_last;
  logic [COORD_W-1:0] scan_x;
  logic [COORD_W-1:0] scan_y;
  logic               set_ovr;
  logic [COORD_W-1:0] nx, ny;
  logic [COLOR_W-1:0] nc;
  logic               np;
  logic               in_ok;

  clear_scanner #(
    .SCREEN_W(SCREEN_W),
    .SCREEN_H(SCREEN_H)
  ) u_scan (
    .clk    (clk),
    .reset  (reset),
    .start  (scan_start),
    .advance(scan_adv),
    .x      (scan_x),
    .y      (scan_y),
    .last   (scan_last)
  );

  assign draw_en = (state == DRAW);
  assign busy    = (state != WAIT);

  // Off-screen pixels never reach the adapter; border pixels are
  // protected from drawing only when the border is painted.
  assign in_ok = in_plot && (in_x < X_LIM) && (in_y < Y_LIM) &&
                 !(BORDER_ON &&
                   on_border(in_x, in_y, SCREEN_W, SCREEN_H));

  always_comb begin
    next       = state;
    scan_start = 1'b0;
    scan_adv   = 1'b0;
    set_ovr    = 1'b0;
    nx         = '0;
    ny         = '0;
    nc         = '0;
    np         = 1'b0;
    unique case (state)
      WAIT: begin
        if (frame_tick) begin
          next       = CLEAR;
          scan_start = 1'b1;
        end
      end
      CLEAR: begin
        scan_adv = 1'b1;
        nx       = scan_x;
        ny       = scan_y;
        np       = 1'b1;
        nc       = (BORDER_ON &&
                    on_border(scan_x, scan_y, SCREEN_W, SCREEN_H))
                   ? BORDER_COLOR : BG_COLOR;
        set_ovr  = frame_tick;
        if (scan_last) next = DRAW;
      end
      DRAW: begin
        nx = in_x;
        ny = in_y;
        nc = in_color;
        np = in_ok;
        if (in_frame_done) begin
          if (frame_tick) begin
            next       = CLEAR;
            scan_start = 1'b1;
          end else begin
            next = WAIT;
          end
        end else begin
          set_ovr = frame_tick;
        end
      end
      default: next = WAIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= WAIT;
      vga_x     <= '0;
      vga_y     <= '0;
      vga_color <= '0;
      vga_plot  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= next;
      vga_x     <= nx;
      vga_y     <= ny;
      vga_color <= nc;
      vga_plot  <= np;
      if (set_ovr) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_frame_clear_mux.sv
// Directed bench for frame_clear_mux on a 4x3 screen.
// Expectations follow FRAME_BORDER_EN when it is defined.
module tb_frame_clear_mux;
  import frame_pkg::*;

  logic               clk = 1'b0;
  logic               reset;
  logic               frame_tick;
  logic [COORD_W-1:0] in_x;
  logic [COORD_W-1:0] in_y;
  logic [COLOR_W-1:0] in_color;
  logic               in_plot;
  logic               in_frame_done;
  logic               draw_en;
  logic [COORD_W-1:0] vga_x;
  logic [COORD_W-1:0] vga_y;
  logic [COLOR_W-1:0] vga_color;
  logic               vga_plot;
  logic               busy;
  logic               overrun;

  int checks = 0;
  int passed = 0;

`ifdef FRAME_BORDER_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif

  frame_clear_mux #(
    .SCREEN_W(4),
    .SCREEN_H(3),
    .BG_COLOR(3'b000),
    .BORDER_COLOR(3'b111)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .frame_tick   (frame_tick),
    .in_x         (in_x),
    .in_y         (in_y),
    .in_color     (in_color),
    .in_plot      (in_plot),
    .in_frame_done(in_frame_done),
    .draw_en      (draw_en),
    .vga_x        (vga_x),
    .vga_y        (vga_y),
    .vga_color    (vga_color),
    .vga_plot     (vga_plot),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int color;
    bit plot;
    bit exp_plot;
    bit exp_plot_b;
  } vec_t;

  vec_t vecs[10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int clr_color(input int x, input int y);
    if (BORDER && (x == 0 || x == 3 || y == 0 || y == 2)) return 7;
    return 0;
  endfunction

  int n;
  int guard;

  initial begin
    vecs[0] = '{2, 1, 5, 1'b1, 1'b1, 1'b1};
    vecs[1] = '{7, 1, 5, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{2, 1, 5, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1, 1, 4, 1'b1, 1'b1, 1'b1};
    vecs[4] = '{0, 1, 3, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{3, 2, 6, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{4, 0, 1, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{0, 3, 2, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{1023, 1023, 7, 1'b1, 1'b0, 1'b0};
    vecs[9] = '{2, 1, 2, 1'b1, 1'b1, 1'b1};

    reset = 1'b1;
    frame_tick = 1'b0;
    in_x = '0;
    in_y = '0;
    in_color = '0;
    in_plot = 1'b0;
    in_frame_done = 1'b0;
    step();
    step();
    chk("rst_plot", int'(vga_plot), 0);
    chk("rst_xy", int'(vga_x) + int'(vga_y), 0);
    chk("rst_color", int'(vga_color), 0);
    chk("rst_draw_en", int'(draw_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overrun", int'(overrun), 0);
    reset = 1'b0;

    // WAIT ignores the draw controller
    in_x = 10'd1; in_y = 10'd1; in_color = 3'd5; in_plot = 1'b1;
    in_frame_done = 1'b1;
    step();
    chk("wait_plot", int'(vga_plot), 0);
    chk("wait_busy", int'(busy), 0);
    in_plot = 1'b0;
    in_frame_done = 1'b0;

    // full clear of 4x3
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    chk("clr_entry_plot", int'(vga_plot), 0);
    chk("clr_entry_busy", int'(busy), 1);
    for (int i = 0; i < 12; i++) begin
      step();
      chk("clr_plot", int'(vga_plot), 1);
      chk("clr_x", int'(vga_x), i % 4);
      chk("clr_y", int'(vga_y), i / 4);
      chk("clr_color", int'(vga_color), clr_color(i % 4, i / 4));
      chk("clr_draw_en", int'(draw_en), (i == 11) ? 1 : 0);
    end
    chk("clr_overrun", int'(overrun), 0);

    // DRAW pass-through table
    foreach (vecs[i]) begin
      in_x = vecs[i].x[COORD_W-1:0];
      in_y = vecs[i].y[COORD_W-1:0];
      in_color = vecs[i].color[COLOR_W-1:0];
      in_plot = vecs[i].plot;
      step();
      chk("draw_plot", int'(vga_plot),
          BORDER ? int'(vecs[i].exp_plot_b) : int'(vecs[i].exp_plot));
      chk("draw_xy", int'(vga_x) * 1024 + int'(vga_y),
          (vecs[i].x % 1024) * 1024 + (vecs[i].y % 1024));
      chk("draw_color", int'(vga_color), vecs[i].color);
      chk("draw_en_hold", int'(draw_en), 1);
    end
    in_plot = 1'b0;

    // simultaneous done + tick restarts the clear
    in_frame_done = 1'b1;
    frame_tick = 1'b1;
    step();
    in_frame_done = 1'b0;
    frame_tick = 1'b0;
    chk("restart_draw_en", int'(draw_en), 0);
    chk("restart_busy", int'(busy), 1);
    chk("restart_overrun", int'(overrun), 0);
    step();
    chk("restart_plot", int'(vga_plot), 1);
    chk("restart_x", int'(vga_x), 0);
    chk("restart_y", int'(vga_y), 0);

    // tick during clear: scan continues, overrun sticks
    n = 1;
    guard = 0;
    while (n < 12 && guard < 20) begin
      frame_tick = (n == 4);
      step();
      guard++;
      if (vga_plot) begin
        chk("ovr_x", int'(vga_x), n % 4);
        chk("ovr_y", int'(vga_y), n / 4);
        n++;
      end
    end
    frame_tick = 1'b0;
    chk("ovr_count", n, 12);
    chk("ovr_draw_en", int'(draw_en), 1);
    chk("ovr_flag", int'(overrun), 1);
    step();
    step();
    chk("ovr_sticky", int'(overrun), 1);

    in_frame_done = 1'b1;
    step();
    in_frame_done = 1'b0;
    chk("done_busy", int'(busy), 0);
    chk("done_draw_en", int'(draw_en), 0);
    chk("done_overrun", int'(overrun), 1);

    // reset in the middle of a clear
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    for (int i = 0; i < 7; i++) step();
    chk("mid_x", int'(vga_x), 2);
    chk("mid_y", int'(vga_y), 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_plot", int'(vga_plot), 0);
    chk("mid_rst_xy", int'(vga_x) + int'(vga_y), 0);
    chk("mid_rst_overrun", int'(overrun), 0);
    chk("mid_rst_busy", int'(busy), 0);
    step();
    reset = 1'b0;
    step();
    chk("post_rst_plot", int'(vga_plot), 0);
    chk("post_rst_busy", int'(busy), 0);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
    chk("again_plot", int'(vga_plot), 1);
    chk("again_xy", int'(vga_x) + int'(vga_y), 0);
    step();
    chk("again_x1", int'(vga_x), 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
